// File: rtl/ir_burst_modulator.sv
// ----------------------------------------------------------------------------
// ir_burst_modulator
//
// Carrier/envelope stage for the IR LED. Each accepted mark/space pair is
// played as `on` carrier periods of square wave followed by `off` silent
// carrier periods, each period P clocks long (high floor(P/2), low the rest).
// A new pair offered on the final clock of the current one follows with no
// gap, and its carrier phase restarts from zero.
//
// Ports
//   clock_in        system clock
//   reset_in        synchronous active-high reset, overrides every other input
//   pair_valid_in   pair fields valid
//   pair_ready_out  pair accepted on a rising edge when valid && ready
//   div_in          carrier period P in clocks (values below 2 act as 2)
//   on_cycles_in    mark length in carrier periods
//   off_cycles_in   space length in carrier periods
//   abort_in        cancel the current pair; blocks acceptance in its clock
//   ctc_out         registered modulated carrier
//   busy_out        high whenever a mark or space is being played
//   pair_done_out   one-clock pulse on the final clock of each pair
// ----------------------------------------------------------------------------
module ir_burst_modulator #(
   parameter int TIME_W = 16,
   parameter int DIV_W  = 10
) (
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              pair_valid_in,
   output logic              pair_ready_out,
   input  logic [DIV_W-1:0]  div_in,
   input  logic [TIME_W-1:0] on_cycles_in,
   input  logic [TIME_W-1:0] off_cycles_in,
   input  logic              abort_in,
   output logic              ctc_out,
   output logic              busy_out,
   output logic              pair_done_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MARK  = 2'd1,
      ST_SPACE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  phase_q, phase_d;   // clock index within the carrier period
   logic [TIME_W-1:0] per_q, per_d;       // carrier periods left in this state, current included
   logic              ctc_q, ctc_d;
   logic              zdone_q, zdone_d;   // done pulse owed to an empty (0/0) pair
   logic [DIV_W-1:0]  div_q;
   logic [TIME_W-1:0] off_q;

   logic [DIV_W-1:0]  div_sat;
   logic [DIV_W-1:0]  phase_adv;
   logic [TIME_W-1:0] per_adv;
   logic              period_end;
   logic              state_last;
   logic              final_clk;
   logic              accept;

   assign div_sat    = (div_in < DIV_W'(2)) ? DIV_W'(2) : div_in;

   assign period_end = (phase_q == (div_q - DIV_W'(1)));
   assign state_last = period_end && (per_q == TIME_W'(1));

   // Last clock of the whole pair: end of SPACE, or end of MARK with no space.
   assign final_clk  = ((state_q == ST_MARK) && state_last && (off_q == '0)) ||
                       ((state_q == ST_SPACE) && state_last);

   assign phase_adv  = period_end ? '0 : (phase_q + DIV_W'(1));
   // Period count only moves on a period boundary and never wraps below zero.
   assign per_adv    = (period_end && (per_q != '0)) ? (per_q - TIME_W'(1)) : per_q;

   assign pair_ready_out = ((state_q == ST_IDLE) || final_clk) && !abort_in;
   assign accept         = pair_valid_in && pair_ready_out && !reset_in;

   assign busy_out      = (state_q != ST_IDLE);
   assign ctc_out       = ctc_q;
   assign pair_done_out = zdone_q || (final_clk && !abort_in && !reset_in);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      per_d   = per_q;
      ctc_d   = 1'b0;
      zdone_d = 1'b0;

      if (abort_in && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         phase_d = '0;
         per_d   = '0;
      end else if (accept) begin
         phase_d = '0;
         if (on_cycles_in != '0) begin
            state_d = ST_MARK;
            per_d   = on_cycles_in;
            ctc_d   = 1'b1;               // P >= 2, so phase 0 is always a high clock
         end else if (off_cycles_in != '0) begin
            state_d = ST_SPACE;
            per_d   = off_cycles_in;
         end else begin
            state_d = ST_IDLE;
            per_d   = '0;
            zdone_d = 1'b1;
         end
      end else begin
         case (state_q)
            ST_MARK: begin
               if (state_last) begin
                  phase_d = '0;
                  if (off_q != '0) begin
                     state_d = ST_SPACE;
                     per_d   = off_q;
                  end else begin
                     state_d = ST_IDLE;
                     per_d   = '0;
                  end
               end else begin
                  phase_d = phase_adv;
                  per_d   = per_adv;
                  // ctc is registered, so it is decoded from the phase of the next clock.
                  ctc_d   = (phase_adv < (div_q >> 1));
               end
            end
            ST_SPACE: begin
               if (state_last) begin
                  state_d = ST_IDLE;
                  phase_d = '0;
                  per_d   = '0;
               end else begin
                  phase_d = phase_adv;
                  per_d   = per_adv;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         per_q   <= '0;
         ctc_q   <= 1'b0;
         zdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         per_q   <= per_d;
         ctc_q   <= ctc_d;
         zdone_q <= zdone_d;
      end
   end

   // Pair fields are captured once at acceptance; later input changes are ignored.
   always_ff @(posedge clock_in) begin
      if (accept) begin
         div_q <= div_sat;
         off_q <= off_cycles_in;
      end
   end

endmodule

// File: tb/tb_ir_burst_modulator.sv
module tb_ir_burst_modulator;
   localparam int TIME_W = 16;
   localparam int DIV_W  = 10;
   localparam int NRAND  = 40;

   logic              clk = 1'b0;
   logic              rst;
   logic              vld;
   logic              rdy;
   logic [DIV_W-1:0]  div;
   logic [TIME_W-1:0] on_c;
   logic [TIME_W-1:0] off_c;
   logic              abort;
   logic              ctc;
   logic              busy;
   logic              done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ir_burst_modulator #(.TIME_W(TIME_W), .DIV_W(DIV_W)) dut (
      .clock_in      (clk),
      .reset_in      (rst),
      .pair_valid_in (vld),
      .pair_ready_out(rdy),
      .div_in        (div),
      .on_cycles_in  (on_c),
      .off_cycles_in (off_c),
      .abort_in      (abort),
      .ctc_out       (ctc),
      .busy_out      (busy),
      .pair_done_out (done)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compares {ctc, done, busy, ready} against the expected 4-bit pattern.
   task automatic chk4(input string name, input logic [3:0] exp);
      logic [3:0] act;
      act = {ctc, done, busy, rdy};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got ctc/done/busy/rdy=%b want %b", name, act, exp);
      end
   endtask

   task automatic chk3(input string name, input logic [2:0] exp);
      logic [2:0] act;
      act = {ctc, done, busy};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got ctc/done/busy=%b want %b", name, act, exp);
      end
   endtask

   typedef struct {
      int    p;
      int    on;
      int    off;
      string wave;   // expected ctc for clocks 1..len after acceptance
   } vec_t;

   vec_t vecs[$];

   // Reference model: expected per-clock {ctc, done, busy, ready} for one pair.
   function automatic void model_pair(input int p, input int on, input int off,
                                      inout logic [3:0] q[$]);
      int pe, len;
      logic c, last;
      pe  = (p < 2) ? 2 : p;
      len = (on + off) * pe;
      for (int i = 0; i < len; i++) begin
         c    = (i < on * pe) && ((i % pe) < (pe / 2));
         last = (i == len - 1);
         q.push_back({c, last, 1'b1, last});
      end
   endfunction

   initial begin
      string      w;
      int         len;
      logic [3:0] e;
      logic [3:0] expq[$];
      int         rp[NRAND];
      int         ron[NRAND];
      int         roff[NRAND];
      int         start[NRAND+1];
      int         idx;

      rst = 1'b1; vld = 1'b0; abort = 1'b0;
      div = '0; on_c = '0; off_c = '0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk4("reset_state", 4'b0001);
      tick();

      // ---------------- table-driven single pairs ----------------
      vecs.push_back('{4, 2, 1, "110011000000"});
      vecs.push_back('{3, 2, 0, "100100"});
      vecs.push_back('{1, 1, 0, "10"});
      vecs.push_back('{0, 1, 0, "10"});
      vecs.push_back('{2, 0, 2, "0000"});
      vecs.push_back('{5, 1, 1, "1100000000"});
      vecs.push_back('{2, 3, 0, "101010"});
      vecs.push_back('{7, 1, 1, "11100000000000"});

      for (int v = 0; v < vecs.size(); v++) begin
         len   = vecs[v].wave.len();
         div   = DIV_W'(vecs[v].p);
         on_c  = TIME_W'(vecs[v].on);
         off_c = TIME_W'(vecs[v].off);
         vld   = 1'b1;
         @(negedge clk);
         chk4($sformatf("vec%0d_idle", v), 4'b0001);
         tick();
         vld = 1'b0;
         for (int t = 1; t <= len + 1; t++) begin
            div   = DIV_W'($urandom);
            on_c  = TIME_W'($urandom);
            off_c = TIME_W'($urandom);
            @(negedge clk);
            e[3] = (t <= len) ? (vecs[v].wave[t-1] == "1") : 1'b0;
            e[2] = (t == len);
            e[1] = (t <= len);
            e[0] = (t >= len);
            chk4($sformatf("vec%0d_clk%0d", v, t), e);
            tick();
         end
      end

      // ---------------- back-to-back A then B ----------------
      w = "11000000100100";
      div = 4; on_c = 1; off_c = 1; vld = 1'b1;
      tick();
      div = 3; on_c = 2; off_c = 0;
      for (int t = 1; t <= 15; t++) begin
         @(negedge clk);
         e[3] = (t <= 14) ? (w[t-1] == "1") : 1'b0;
         e[2] = (t == 8) || (t == 14);
         e[1] = (t <= 14);
         e[0] = (t == 8) || (t >= 14);
         chk4($sformatf("b2b_clk%0d", t), e);
         tick();
         if (t == 8) vld = 1'b0;
      end

      // ---------------- empty pair ----------------
      div = 4; on_c = 0; off_c = 0; vld = 1'b1;
      tick();
      vld = 1'b0;
      @(negedge clk);
      chk4("zero_clk1", 4'b0101);
      tick();
      @(negedge clk);
      chk4("zero_clk2", 4'b0001);
      tick();

      // ---------------- abort mid-mark ----------------
      w = "1100110";
      div = 4; on_c = 10; off_c = 10; vld = 1'b1;
      tick();
      vld = 1'b0;
      for (int t = 1; t <= 7; t++) begin
         if (t == 7) begin
            abort = 1'b1;
            vld   = 1'b1;
            div = 4; on_c = 1; off_c = 0;
         end
         @(negedge clk);
         e = {(w[t-1] == "1"), 1'b0, 1'b1, 1'b0};
         chk4($sformatf("abort_clk%0d", t), e);
         tick();
      end
      abort = 1'b0;
      @(negedge clk);
      chk4("abort_clk8", 4'b0001);
      tick();
      vld = 1'b0;
      w = "1100";
      for (int t = 9; t <= 13; t++) begin
         @(negedge clk);
         e[3] = (t <= 12) ? (w[t-9] == "1") : 1'b0;
         e[2] = (t == 12);
         e[1] = (t <= 12);
         e[0] = (t >= 12);
         chk4($sformatf("after_abort_clk%0d", t), e);
         tick();
      end

      // ---------------- reset during space, valid held ----------------
      w = "11000";
      div = 4; on_c = 1; off_c = 3; vld = 1'b1;
      tick();
      div = 2; on_c = 1; off_c = 0;
      for (int t = 1; t <= 5; t++) begin
         @(negedge clk);
         e = {(w[t-1] == "1"), 1'b0, 1'b1, 1'b0};
         chk4($sformatf("rstmid_clk%0d", t), e);
         tick();
      end
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk3("rstmid_clk7", 3'b000);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk4("rstmid_clk8", 4'b0001);
      tick();
      vld = 1'b0;
      @(negedge clk);
      chk4("rstmid_clk9", 4'b1010);
      tick();
      @(negedge clk);
      chk4("rstmid_clk10", 4'b0111);
      tick();

      // ---------------- randomized back-to-back stream ----------------
      start[0] = 0;
      for (int k = 0; k < NRAND; k++) begin
         rp[k]   = $urandom_range(0, 9);
         ron[k]  = $urandom_range(0, 4);
         roff[k] = $urandom_range(0, 4);
         if (ron[k] + roff[k] == 0) roff[k] = 1;
         model_pair(rp[k], ron[k], roff[k], expq);
         start[k+1] = expq.size();
      end
      idx   = 0;
      div   = DIV_W'(rp[0]);
      on_c  = TIME_W'(ron[0]);
      off_c = TIME_W'(roff[0]);
      vld   = 1'b1;
      tick();
      idx   = 1;
      div   = DIV_W'(rp[1]);
      on_c  = TIME_W'(ron[1]);
      off_c = TIME_W'(roff[1]);
      for (int t = 1; t <= start[NRAND] + 1; t++) begin
         @(negedge clk);
         e = (t <= start[NRAND]) ? expq[t-1] : 4'b0001;
         chk4($sformatf("rand_clk%0d", t), e);
         tick();
         if ((idx < NRAND) && (t == start[idx])) begin
            idx++;
            if (idx < NRAND) begin
               div   = DIV_W'(rp[idx]);
               on_c  = TIME_W'(ron[idx]);
               off_c = TIME_W'(roff[idx]);
            end else begin
               vld = 1'b0;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
